// File: rtl/vx_commit_arb_if.sv
// Commit-arbiter bundle: per-channel commit inputs, the writeback stream and the CSR commit count.
// master = arbiter side, slave = execute units / writeback consumer side.
interface vx_commit_arb_if #(
  parameter int NUM_CH      = 6,
  parameter int NUM_THREADS = 4,
  parameter int DATA_W      = 32,
  parameter int WID_W       = 2,
  parameter int RD_W        = 5
);
  localparam int CNT_W = $clog2(NUM_CH * NUM_THREADS + 1);

  logic [NUM_CH-1:0]                    ch_valid;
  logic [NUM_CH-1:0]                    ch_ready;
  logic [NUM_CH-1:0]                    ch_wb;
  logic [NUM_CH*WID_W-1:0]              ch_wid;
  logic [NUM_CH*NUM_THREADS-1:0]        ch_tmask;
  logic [NUM_CH*RD_W-1:0]               ch_rd;
  logic [NUM_CH*NUM_THREADS*DATA_W-1:0] ch_data;

  logic                                 wb_valid;
  logic                                 wb_ready;
  logic [WID_W-1:0]                     wb_wid;
  logic [NUM_THREADS-1:0]               wb_tmask;
  logic [RD_W-1:0]                      wb_rd;
  logic [NUM_THREADS*DATA_W-1:0]        wb_data;

  logic                                 cmt_valid;
  logic [CNT_W-1:0]                     cmt_size;

  modport master (
    input  ch_valid, ch_wb, ch_wid, ch_tmask, ch_rd, ch_data, wb_ready,
    output ch_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, cmt_valid, cmt_size
  );

  modport slave (
    output ch_valid, ch_wb, ch_wid, ch_tmask, ch_rd, ch_data, wb_ready,
    input  ch_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, cmt_valid, cmt_size
  );
endinterface

// File: rtl/vx_commit_arb.sv
// Commit arbiter: round-robin grant of one writeback channel per cycle, registered commit count.
// Optional 64-bit perf counters when VX_COMMIT_PERF_EN is defined.
module vx_commit_arb #(
  parameter int NUM_CH      = 6,
  parameter int NUM_THREADS = 4,
  parameter int DATA_W      = 32,
  parameter int WID_W       = 2,
  parameter int RD_W        = 5
) (
  input  logic            clk,
  input  logic            reset,
  vx_commit_arb_if.master bus
`ifdef VX_COMMIT_PERF_EN
  ,
  output logic [63:0]     perf_commits,
  output logic [63:0]     perf_wb_stalls
`endif
);
  localparam int CNT_W = $clog2(NUM_CH * NUM_THREADS + 1);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]             req, grant, fire;
  logic [PTR_W-1:0]              rr_ptr, grant_idx;
  logic                          grant_any, slot_free, grant_fire;
  logic [CNT_W-1:0]              fire_cnt;
  logic [WID_W-1:0]              sel_wid;
  logic [NUM_THREADS-1:0]        sel_tmask;
  logic [RD_W-1:0]               sel_rd;
  logic [NUM_THREADS*DATA_W-1:0] sel_data;

  assign req        = bus.ch_valid & bus.ch_wb;
  assign slot_free  = !bus.wb_valid || bus.wb_ready;
  // Gating with reset keeps writeback channels stalled while reset is held.
  assign grant_fire = grant_any && slot_free && reset;

  // Round-robin search: first requester at or after rr_ptr, wrapping at NUM_CH.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    grant     = '0;
    fire_cnt  = '0;
    sel_wid   = '0;
    sel_tmask = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i]        = grant_any && (int'(grant_idx) == i);
      bus.ch_ready[i] = !bus.ch_wb[i] || (grant[i] && slot_free && reset);
      fire[i]         = bus.ch_valid[i] && bus.ch_ready[i];
      if (fire[i]) begin
        for (int t = 0; t < NUM_THREADS; t++)
          fire_cnt = fire_cnt + CNT_W'(bus.ch_tmask[i*NUM_THREADS+t]);
      end
      if (grant[i]) begin
        sel_wid   = bus.ch_wid[i*WID_W +: WID_W];
        sel_tmask = bus.ch_tmask[i*NUM_THREADS +: NUM_THREADS];
        sel_rd    = bus.ch_rd[i*RD_W +: RD_W];
        sel_data  = bus.ch_data[i*NUM_THREADS*DATA_W +: NUM_THREADS*DATA_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_wid    <= '0;
      bus.wb_tmask  <= '0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.cmt_valid <= 1'b0;
      bus.cmt_size  <= '0;
    end else begin
      if (grant_fire) begin
        rr_ptr       <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + PTR_W'(1);
        bus.wb_valid <= 1'b1;
        bus.wb_wid   <= sel_wid;
        bus.wb_tmask <= sel_tmask;
        bus.wb_rd    <= sel_rd;
        bus.wb_data  <= sel_data;
      end else if (bus.wb_ready) begin
        bus.wb_valid <= 1'b0;
      end
      bus.cmt_valid <= |fire;
      bus.cmt_size  <= fire_cnt;
    end
  end

`ifdef VX_COMMIT_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_commits   <= '0;
      perf_wb_stalls <= '0;
    end else begin
      if (bus.cmt_valid)                 perf_commits   <= perf_commits + 64'(bus.cmt_size);
      if (bus.wb_valid && !bus.wb_ready) perf_wb_stalls <= perf_wb_stalls + 64'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vx_commit_arb.sv
// Randomized self-checking bench for vx_commit_arb against a queue-free behavioural model.
module tb_vx_commit_arb;
  localparam int NUM_CH      = 6;
  localparam int NUM_THREADS = 4;
  localparam int DATA_W      = 32;
  localparam int WID_W       = 2;
  localparam int RD_W        = 5;
  localparam int CNT_W       = $clog2(NUM_CH * NUM_THREADS + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_commit_arb_if #(.NUM_CH(NUM_CH), .NUM_THREADS(NUM_THREADS), .DATA_W(DATA_W),
                     .WID_W(WID_W), .RD_W(RD_W)) bus();
`ifdef VX_COMMIT_PERF_EN
  logic [63:0] perf_commits, perf_wb_stalls;
`endif

  vx_commit_arb #(.NUM_CH(NUM_CH), .NUM_THREADS(NUM_THREADS), .DATA_W(DATA_W),
                  .WID_W(WID_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef VX_COMMIT_PERF_EN
    ,
    .perf_commits   (perf_commits),
    .perf_wb_stalls (perf_wb_stalls)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  int                            m_ptr;
  logic                          m_wb_valid;
  logic [WID_W-1:0]              m_wid;
  logic [NUM_THREADS-1:0]        m_tmask;
  logic [RD_W-1:0]               m_rd;
  logic [NUM_THREADS*DATA_W-1:0] m_data;
  logic                          m_cmt_valid;
  int                            m_cmt_size;
`ifdef VX_COMMIT_PERF_EN
  longint unsigned               m_perf_commits, m_perf_stalls;
`endif

  task automatic model_reset();
    m_ptr = 0; m_wb_valid = 1'b0; m_wid = '0; m_tmask = '0; m_rd = '0; m_data = '0;
    m_cmt_valid = 1'b0; m_cmt_size = 0;
`ifdef VX_COMMIT_PERF_EN
    m_perf_commits = 0; m_perf_stalls = 0;
`endif
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (bus.ch_valid[c] && bus.ch_wb[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ready();
    logic [NUM_CH-1:0] r;
    int   gi;
    logic slot;
    gi   = model_grant();
    slot = !m_wb_valid || bus.wb_ready;
    for (int i = 0; i < NUM_CH; i++) r[i] = !bus.ch_wb[i] || (reset && slot && gi == i);
    return r;
  endfunction

  task automatic drive_idle();
    bus.ch_valid = '0; bus.ch_wb = '0; bus.ch_wid = '0; bus.ch_tmask = '0;
    bus.ch_rd = '0; bus.ch_data = '0; bus.wb_ready = 1'b1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic wb, input logic [NUM_THREADS-1:0] tm);
    bus.ch_valid[i] = v;
    bus.ch_wb[i]    = wb;
    bus.ch_tmask[i*NUM_THREADS +: NUM_THREADS] = tm;
    bus.ch_wid[i*WID_W +: WID_W] = WID_W'($urandom);
    bus.ch_rd[i*RD_W +: RD_W]    = RD_W'($urandom);
    for (int t = 0; t < NUM_THREADS; t++)
      bus.ch_data[(i*NUM_THREADS+t)*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Called with inputs already driven, away from the edge; checks ready, clocks once, checks outputs.
  task automatic cycle_check(input string tag);
    logic [NUM_CH-1:0] er, fires;
    int   gi, sz;
    logic slot;
    #1;
    er = model_ready();
    vectors++;
    if (bus.ch_ready !== er) begin
      miscompares++;
      $display("FAIL %s ch_ready: got %b expected %b", tag, bus.ch_ready, er);
    end
    gi    = model_grant();
    slot  = !m_wb_valid || bus.wb_ready;
    fires = bus.ch_valid & er;
    sz    = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (fires[i]) sz += $countones(bus.ch_tmask[i*NUM_THREADS +: NUM_THREADS]);
`ifdef VX_COMMIT_PERF_EN
    if (m_wb_valid && !bus.wb_ready) m_perf_stalls++;
    if (m_cmt_valid) m_perf_commits += longint'(m_cmt_size);
`endif
    if (gi >= 0 && slot) begin
      m_wb_valid = 1'b1;
      m_wid   = bus.ch_wid[gi*WID_W +: WID_W];
      m_tmask = bus.ch_tmask[gi*NUM_THREADS +: NUM_THREADS];
      m_rd    = bus.ch_rd[gi*RD_W +: RD_W];
      m_data  = bus.ch_data[gi*NUM_THREADS*DATA_W +: NUM_THREADS*DATA_W];
      m_ptr   = (gi + 1) % NUM_CH;
    end else if (bus.wb_ready) begin
      m_wb_valid = 1'b0;
    end
    m_cmt_valid = |fires;
    m_cmt_size  = sz;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.wb_valid !== m_wb_valid) begin
      miscompares++;
      $display("FAIL %s wb_valid: got %b expected %b", tag, bus.wb_valid, m_wb_valid);
    end
    vectors++;
    if ({bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data} !== {m_wid, m_tmask, m_rd, m_data}) begin
      miscompares++;
      $display("FAIL %s wb_payload: got wid=%h tmask=%b rd=%0d data=%h expected wid=%h tmask=%b rd=%0d data=%h",
               tag, bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data, m_wid, m_tmask, m_rd, m_data);
    end
    vectors++;
    if (bus.cmt_valid !== m_cmt_valid || int'(bus.cmt_size) != m_cmt_size) begin
      miscompares++;
      $display("FAIL %s cmt: got valid=%b size=%0d expected valid=%b size=%0d",
               tag, bus.cmt_valid, bus.cmt_size, m_cmt_valid, m_cmt_size);
    end
`ifdef VX_COMMIT_PERF_EN
    vectors++;
    if (perf_commits !== m_perf_commits || perf_wb_stalls !== m_perf_stalls) begin
      miscompares++;
      $display("FAIL %s perf: got commits=%0d stalls=%0d expected commits=%0d stalls=%0d",
               tag, perf_commits, perf_wb_stalls, m_perf_commits, m_perf_stalls);
    end
`endif
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    #3;
    vectors++;
    if ({bus.wb_valid, bus.cmt_valid, bus.cmt_size, bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got wb_valid=%b cmt_valid=%b cmt_size=%0d rd=%0d expected all zero",
               bus.wb_valid, bus.cmt_valid, bus.cmt_size, bus.wb_rd);
    end
    bus.ch_valid = '1;
    bus.ch_wb    = 6'b101010;
    #1;
    vectors++;
    if (bus.ch_ready !== 6'b010101) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected %b", bus.ch_ready, 6'b010101);
    end
    reset_dut();
  endtask

  task automatic test_basic();
    reset_dut();
    set_ch(0, 1'b1, 1'b1, 4'b1111);
    bus.ch_rd[0 +: RD_W] = 5'd3;
    #1;
    vectors++;
    if (bus.ch_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_ready0: got %b expected 1", bus.ch_ready[0]);
    end
    cycle_check("basic");
    vectors++;
    if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3 || bus.cmt_valid !== 1'b1 || bus.cmt_size !== CNT_W'(4)) begin
      miscompares++;
      $display("FAIL basic_out: got wb_valid=%b rd=%0d cmt_valid=%b size=%0d expected 1 3 1 4",
               bus.wb_valid, bus.wb_rd, bus.cmt_valid, bus.cmt_size);
    end
    drive_idle();
    cycle_check("basic_drain");
  endtask

  task automatic test_round_robin();
    reset_dut();
    bus.ch_wb = '1;
    set_ch(0, 1'b1, 1'b1, 4'($urandom));
    set_ch(2, 1'b1, 1'b1, 4'($urandom));
    #1;
    vectors++;
    if (bus.ch_ready !== 6'b000001) begin
      miscompares++;
      $display("FAIL rr_grant0: got %b expected %b", bus.ch_ready, 6'b000001);
    end
    cycle_check("rr0");
    vectors++;
    if (bus.ch_ready !== 6'b000100) begin
      miscompares++;
      $display("FAIL rr_grant2: got %b expected %b", bus.ch_ready, 6'b000100);
    end
    cycle_check("rr1");
    vectors++;
    if (int'(dut.rr_ptr) != 3) begin
      miscompares++;
      $display("FAIL rr_ptr: got %0d expected 3", dut.rr_ptr);
    end
    drive_idle();
    cycle_check("rr_drain");
  endtask

  task automatic test_stall();
    logic [NUM_THREADS-1:0] tm;
    logic [WID_W+NUM_THREADS+RD_W+NUM_THREADS*DATA_W-1:0] held;
    reset_dut();
    set_ch(0, 1'b1, 1'b1, 4'($urandom));
    cycle_check("stall_load");
    held = {m_wid, m_tmask, m_rd, m_data};
    bus.wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tm = 4'($urandom);
      set_ch(1, 1'b1, 1'b0, tm);
      #1;
      vectors++;
      if (bus.ch_ready[1:0] !== 2'b10) begin
        miscompares++;
        $display("FAIL stall_ready: got %b expected 10", bus.ch_ready[1:0]);
      end
      cycle_check("stall");
      vectors++;
      if ({bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data} !== held || bus.wb_valid !== 1'b1
          || int'(bus.cmt_size) != $countones(tm)) begin
        miscompares++;
        $display("FAIL stall_hold: got wb_valid=%b rd=%0d cmt_size=%0d expected 1 %0d %0d",
                 bus.wb_valid, bus.wb_rd, bus.cmt_size, held[NUM_THREADS*DATA_W +: RD_W], $countones(tm));
      end
    end
    drive_idle();
    cycle_check("stall_drain0");
    cycle_check("stall_drain1");
  endtask

  task automatic test_all_fire();
    int k;
    reset_dut();
    k = int'($urandom_range(NUM_CH - 1));
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, (i == k), 4'b1111);
    cycle_check("all_fire");
    vectors++;
    if (bus.cmt_size !== CNT_W'(24)) begin
      miscompares++;
      $display("FAIL all_fire_size: got %0d expected 24", bus.cmt_size);
    end
    set_ch(3, 1'b1, 1'b0, 4'b0000);
    bus.ch_valid = 6'b001000;
    cycle_check("zero_tmask");
    vectors++;
    if (bus.cmt_valid !== 1'b1 || bus.cmt_size !== '0) begin
      miscompares++;
      $display("FAIL zero_tmask: got valid=%b size=%0d expected 1 0", bus.cmt_valid, bus.cmt_size);
    end
    drive_idle();
  endtask

  task automatic test_reset_midxfer();
    reset_dut();
    set_ch(4, 1'b1, 1'b1, 4'($urandom));
    bus.wb_ready = 1'b0;
    cycle_check("mid_load");
    bus.ch_valid = '1;
    bus.ch_wb    = '1;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.wb_valid !== 1'b0 || int'(dut.rr_ptr) != 0 || bus.ch_ready !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got wb_valid=%b ptr=%0d ready=%b expected 0 0 000000",
               bus.wb_valid, dut.rr_ptr, bus.ch_ready);
    end
    reset_dut();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'($urandom), 1'($urandom), 4'($urandom));
      bus.wb_ready = ($urandom_range(9) < 7);
      cycle_check("random");
    end
    drive_idle();
    cycle_check("random_drain");
  endtask

`ifdef VX_COMMIT_PERF_EN
  task automatic test_perf();
    reset_dut();
    set_ch(0, 1'b1, 1'b1, 4'b0011);
    bus.wb_ready = 1'b0;
    cycle_check("perf_load");
    bus.ch_valid = '0;
    cycle_check("perf_stall0");
    cycle_check("perf_stall1");
    bus.wb_ready = 1'b1;
    set_ch(1, 1'b1, 1'b0, 4'b0011);
    cycle_check("perf_c1");
    cycle_check("perf_c2");
    drive_idle();
    cycle_check("perf_idle0");
    cycle_check("perf_idle1");
    vectors++;
    if (perf_wb_stalls !== 64'd2 || perf_commits !== 64'd6) begin
      miscompares++;
      $display("FAIL perf_totals: got stalls=%0d commits=%0d expected 2 6", perf_wb_stalls, perf_commits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_all_fire();
    test_reset_midxfer();
    test_random();
`ifdef VX_COMMIT_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vx_commit_arb.md
VX_COMMIT_ARB -- requirements
Module: VX_commit_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning number of execute-unit commit channels (1..16).
REQ-002 SHALL have parameter NUM_THREADS, default 4, meaning threads per warp.
REQ-003 SHALL have parameter DATA_W, default 32, meaning per-thread writeback data width.
REQ-004 SHALL have parameter WID_W, default 2, meaning warp-id width.
REQ-005 SHALL have parameter RD_W, default 5, meaning destination-register index width.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port reset, input, 1, meaning the asynchronous active-low reset.
REQ-008 SHALL have port ch_valid, input, NUM_CH, meaning per-channel commit valid.
REQ-009 SHALL have port ch_ready, output, NUM_CH, meaning per-channel commit accept.
REQ-010 SHALL have port ch_wb, input, NUM_CH, meaning per-channel writeback required.
REQ-011 SHALL have port ch_wid, input, NUM_CH*WID_W, meaning per-channel warp id.
REQ-012 SHALL have port ch_tmask, input, NUM_CH*NUM_THREADS, meaning per-channel thread mask.
REQ-013 SHALL have port ch_rd, input, NUM_CH*RD_W, meaning per-channel destination register.
REQ-014 SHALL have port ch_data, input, NUM_CH*NUM_THREADS*DATA_W, meaning per-channel result data.
REQ-015 SHALL have ports wb_valid/wb_ready (output/input, 1) and wb_wid/wb_tmask/wb_rd/wb_data (outputs, WID_W/NUM_THREADS/RD_W/NUM_THREADS*DATA_W), meaning the writeback stream.
REQ-016 SHALL have ports cmt_valid (output, 1) and cmt_size (output, clog2(NUM_CH*NUM_THREADS+1)), meaning committed-thread count to CSRs.

Function
REQ-017 Channel fire SHALL be ch_valid[i] && ch_ready[i].
REQ-018 ch_ready[i] SHALL be 1 combinationally whenever ch_wb[i]=0 (no-writeback commits never stall).
REQ-019 Among channels with ch_valid && ch_wb, exactly one SHALL be granted per cycle by round-robin, and only when slot_free = !wb_valid || wb_ready.
REQ-020 ch_ready[i] for a wb=1 channel SHALL be grant[i] && slot_free; ch_ready SHALL not depend on ch_ready of other channels.
REQ-021 Round-robin priority SHALL start at channel 0 after reset and move to (granted index + 1) mod NUM_CH after each grant; unchanged if no grant.
REQ-022 On grant, wid/tmask/rd/data of the granted channel SHALL load into the output register next cycle with wb_valid=1 (latency 1).
REQ-023 The output register SHALL hold stable while wb_valid && !wb_ready; back-to-back grants SHALL sustain one writeback per cycle when wb_ready=1.
REQ-024 cmt_valid SHALL be registered OR of all channel fires; cmt_size SHALL be registered popcount of the concatenation of all fired channels' tmasks (latency 1, max NUM_CH*NUM_THREADS, no overflow).
REQ-025 A fire with tmask=0 SHALL assert cmt_valid with cmt_size=0.

Reset
REQ-026 While reset=0: wb_valid=0, cmt_valid=0, cmt_size=0, wb_wid/wb_tmask/wb_rd/wb_data=0, round-robin pointer=0, perf counters=0; asserted asynchronously.
REQ-027 Reset mid-transfer SHALL discard the held writeback; ch_ready for wb=1 channels SHALL be 0 while in reset.

Configuration
REQ-028 With macro VX_COMMIT_PERF_EN defined, SHALL add outputs perf_commits (64-bit, accumulates cmt_size each cmt_valid cycle) and perf_wb_stalls (64-bit, increments each cycle wb_valid && !wb_ready); both wrap modulo 2^64.
REQ-029 Without VX_COMMIT_PERF_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset then ch_valid=6'b000001, ch_wb=1, tmask=4'b1111, rd=3, wb_ready=1 -> ch_ready[0]=1; next cycle wb_valid=1, wb_rd=3, cmt_valid=1, cmt_size=4.
REQ-031 ch_valid=6'b000101 both wb=1, wb_ready=1 held -> grants ch0 then ch2 in consecutive cycles; pointer=3 afterward.
REQ-032 ch0 wb=1 valid, wb_ready=0 for 3 cycles after first writeback -> wb_* stable, ch_ready[0]=0, ch_valid=6'b000010 wb=0 still fires each cycle with cmt_size=popcount(tmask).
REQ-033 All 6 channels fire in one cycle (one wb=1 granted, five wb=0), all tmask=4'b1111 -> cmt_size=24.
REQ-034 Assert reset low while wb_valid=1 && wb_ready=0 -> wb_valid=0 immediately (before next clk edge), pointer=0.
REQ-035 With VX_COMMIT_PERF_EN, 2 stall cycles then 3 commits of tmask=4'b0011 -> perf_wb_stalls=2, perf_commits=6.
